price_frame_parser: RTL and testbench
=====================================

PRICE_FRAME_PARSER -- requirements
Module: price_frame_parser

Interface
REQ-001 SHALL provide parameter SYNC_BYTE, default 8'hAA, the frame start marker.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 100000, the maximum clk cycles allowed between bytes of one frame.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART byte receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe marking rx_data as valid.
REQ-007 SHALL have port price_out  output  16  price of the last good frame, big-endian assembly.
REQ-008 SHALL have port symbol_out  output  8  symbol ID of the last good frame.
REQ-009 SHALL have port price_valid  output  1  one-cycle strobe marking a newly updated price_out/symbol_out.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe on checksum failure or timeout.
REQ-011 SHALL have port err_count  output  8  saturating count of frame errors.
REQ-012 SHALL have port busy  output  1  high whenever the parser is in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, SYM, PHI, PLO, CSUM; the frame is SYNC_BYTE, symbol, price_hi, price_lo, checksum.
REQ-014 IDLE: rx_valid with rx_data==SYNC_BYTE -> SYM; any other byte is discarded silently with no error.
REQ-015 SYM/PHI/PLO: each rx_valid captures the byte into a holding register and advances to PHI/PLO/CSUM respectively.
REQ-016 Mid-frame, a byte equal to SYNC_BYTE SHALL be treated as data (no resynchronisation).
REQ-017 CSUM: rx_valid SHALL compare rx_data against symbol XOR price_hi XOR price_lo and return to IDLE.
REQ-018 On match, the block SHALL update price_out={price_hi,price_lo} and symbol_out, and pulse price_valid for exactly one cycle, in the cycle after the checksum byte's rx_valid (latency 1).
REQ-019 On mismatch, the block SHALL pulse frame_err for one cycle (latency 1), increment err_count, and leave price_out/symbol_out unchanged.
REQ-020 SHALL keep a gap counter, cleared on every rx_valid and on entry to IDLE, that increments each cycle while not in IDLE.
REQ-021 Gap counter reaching TIMEOUT_CYCLES SHALL force IDLE, pulse frame_err for one cycle, and increment err_count; the partial frame is dropped.
REQ-022 If rx_valid coincides with the timeout cycle, rx_valid SHALL win: the byte is processed and no timeout occurs.
REQ-023 err_count SHALL saturate at 255 and never wrap.
REQ-024 price_valid and frame_err SHALL never be asserted in the same cycle.
REQ-025 The gap counter SHALL be wide enough for TIMEOUT_CYCLES with no overflow.

Reset
REQ-026 While rst is high, the block SHALL hold state IDLE, and price_out, symbol_out, err_count, the gap counter and holding registers at 0, and price_valid, frame_err and busy at 0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame; after release, the parser SHALL require a fresh SYNC_BYTE.

Verification
REQ-028 Bytes AA 03 01 2C 2E -> price_valid pulse 1 cycle after the last strobe; price_out=16'h012C (300); symbol_out=8'h03; err_count=0.
REQ-029 Bytes AA 03 01 2C 00 -> frame_err pulse; err_count=1; price_out and symbol_out keep their prior values; no price_valid.
REQ-030 Bytes AA 03 followed by TIMEOUT_CYCLES idle cycles -> frame_err pulse; busy=0; next frame AA 07 00 64 63 -> price_out=100, symbol_out=7.
REQ-031 Bytes 55 12 AA 03 01 2C 2E -> no frame_err; single price_valid; price_out=300.
REQ-032 256 bad-checksum frames -> err_count=255 after the 255th and remains 255 after the 256th.
REQ-033 rst pulse after AA 03 01, then bytes 2C 2E -> no price_valid, no frame_err, all outputs 0.

Source files
------------

// File: rtl/price_frame_parser.sv
// Byte-stream parser for 5-byte price frames: SYNC, symbol, price_hi, price_lo, checksum.
// A good frame updates price/symbol; a bad checksum or an inter-byte timeout counts an error.
//
// state | meaning
// IDLE  | hunting for SYNC_BYTE, other bytes ignored
// SYM   | waiting for symbol byte
// PHI   | waiting for price high byte
// PLO   | waiting for price low byte
// CSUM  | waiting for checksum byte
module price_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] price_out,
  output logic [7:0]  symbol_out,
  output logic        price_valid,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SYM, PHI, PLO, CSUM} state_t;

  state_t           state, state_nxt;
  logic [7:0]       sym_q, phi_q, plo_q;
  logic [GAP_W-1:0] gap_q;
  logic             timeout, csum_byte, csum_ok, err_inc;

  // A byte arriving in the timeout cycle takes priority over the timeout.
  assign timeout   = (state != IDLE) && !rx_valid && (gap_q == GAP_W'(TIMEOUT_CYCLES));
  assign csum_byte = (state == CSUM) && rx_valid;
  assign csum_ok   = (rx_data == (sym_q ^ phi_q ^ plo_q));
  assign err_inc   = timeout || (csum_byte && !csum_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE:    if (rx_data == SYNC_BYTE) state_nxt = SYM;
        SYM:     state_nxt = PHI;
        PHI:     state_nxt = PLO;
        PLO:     state_nxt = CSUM;
        CSUM:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_q       <= 8'h00;
      phi_q       <= 8'h00;
      plo_q       <= 8'h00;
      gap_q       <= '0;
      price_out   <= 16'h0000;
      symbol_out  <= 8'h00;
      price_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= 8'h00;
    end else begin
      if (rx_valid || state_nxt == IDLE) gap_q <= '0;
      else                               gap_q <= gap_q + GAP_W'(1);

      if (rx_valid && state == SYM) sym_q <= rx_data;
      if (rx_valid && state == PHI) phi_q <= rx_data;
      if (rx_valid && state == PLO) plo_q <= rx_data;

      price_valid <= csum_byte && csum_ok;
      frame_err   <= err_inc;

      if (csum_byte && csum_ok) begin
        price_out  <= {phi_q, plo_q};
        symbol_out <= sym_q;
      end

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_price_frame_parser.sv
// Scoreboard bench for price_frame_parser: stimulus pushes expected strobes,
// a negedge monitor pops and compares each price_valid / frame_err event.
module tb_price_frame_parser;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] price_out;
  logic [7:0]  symbol_out;
  logic        price_valid, frame_err, busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] price;
    logic [7:0]  sym;
    logic [7:0]  errc;
  } exp_t;

  exp_t q[$];
  logic [15:0] exp_price = 16'h0000;
  logic [7:0]  exp_sym   = 8'h00;
  logic [7:0]  exp_err   = 8'h00;

  price_frame_parser #(.SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .price_out(price_out), .symbol_out(symbol_out), .price_valid(price_valid),
    .frame_err(frame_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (price_valid || frame_err)) begin
      chk("exclusive_strobes", {31'b0, price_valid & frame_err}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got pv=%0b fe=%0b expected no strobe at %0t",
                 price_valid, frame_err, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", {31'b0, frame_err}, {31'b0, e.is_err});
        chk("price_out", {16'b0, price_out}, {16'b0, e.price});
        chk("symbol_out", {24'b0, symbol_out}, {24'b0, e.sym});
        chk("err_count", {24'b0, err_count}, {24'b0, e.errc});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo,
                       input logic [7:0] cs);
    send_byte(8'hAA); send_byte(s); send_byte(hi); send_byte(lo); send_byte(cs);
  endtask

  task automatic push_good(input logic [15:0] p, input logic [7:0] s);
    exp_t e;
    exp_price = p;
    exp_sym   = s;
    e.is_err = 1'b0; e.price = p; e.sym = s; e.errc = exp_err;
    q.push_back(e);
  endtask

  task automatic push_bad();
    exp_t e;
    if (exp_err != 8'hFF) exp_err = exp_err + 8'h01;
    e.is_err = 1'b1; e.price = exp_price; e.sym = exp_sym; e.errc = exp_err;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 4 * T) begin @(posedge clk); #1; n++; end
    idle(3);
    chk(name, q.size(), 32'd0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_price"}, {16'b0, price_out}, 32'd0);
    chk({name, "_symbol"}, {24'b0, symbol_out}, 32'd0);
    chk({name, "_errc"}, {24'b0, err_count}, 32'd0);
    chk({name, "_strobes"}, {30'b0, price_valid, frame_err}, 32'd0);
    chk({name, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    idle(3);
    chk_zero("reset");
    rst = 1'b0;
    idle(2);

    // good frame, price 300 symbol 3
    push_good(16'h012C, 8'h03);
    frame(8'h03, 8'h01, 8'h2C, 8'h2E);
    drain("good_frame");

    // bad checksum keeps previous price/symbol
    push_bad();
    frame(8'h03, 8'h01, 8'h2C, 8'h00);
    drain("bad_csum");

    // timeout after AA 03
    push_bad();
    send_byte(8'hAA); send_byte(8'h03);
    idle(T + 3);
    chk("timeout_busy", {31'b0, busy}, 32'd0);
    drain("timeout");
    push_good(16'h0064, 8'h07);
    frame(8'h07, 8'h00, 8'h64, 8'h63);
    drain("after_timeout");

    // junk before sync is discarded silently
    push_good(16'h012C, 8'h03);
    send_byte(8'h55); send_byte(8'h12);
    frame(8'h03, 8'h01, 8'h2C, 8'h2E);
    drain("junk_prefix");

    // sync value mid-frame is plain data
    push_good(16'hAA00, 8'h01);
    frame(8'h01, 8'hAA, 8'h00, 8'hAB);
    drain("sync_as_data");

    // gaps of T-1 idle cycles between bytes never time out
    push_good(16'h1234, 8'h05);
    send_byte(8'hAA); idle(T - 1);
    send_byte(8'h05); idle(T - 1);
    chk("slow_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h12); idle(T - 1);
    send_byte(8'h34); idle(T - 1);
    send_byte(8'h23);
    drain("slow_frame");

    // byte arriving in the timeout cycle wins
    push_good(16'h0001, 8'h09);
    send_byte(8'hAA); send_byte(8'h09);
    idle(T);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h08);
    drain("valid_beats_timeout");

    // reset mid-frame drops the partial frame
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
    rst = 1'b1;
    idle(2);
    chk_zero("mid_reset");
    rst = 1'b0;
    exp_err = 8'h00; exp_price = 16'h0000; exp_sym = 8'h00;
    idle(1);
    send_byte(8'h2C); send_byte(8'h2E);
    drain("post_reset");
    chk_zero("post_reset");

    // 256 bad frames: err_count saturates at 255
    for (int k = 0; k < 256; k++) begin
      push_bad();
      frame(8'h01, 8'h02, 8'h03, 8'hFF);
      if (k == 254) begin
        drain("sat_255th");
        chk("err_at_255", {24'b0, err_count}, 32'd255);
      end
    end
    drain("saturation");
    chk("err_saturated", {24'b0, err_count}, 32'd255);
    chk("sat_price", {16'b0, price_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
